ahb_decoder_master_split: RTL and testbench

//  Per-master AHB address decoder, next generation of the generated decoder.
//  - Parametrised slave count and address map; inclusive full-width region compare.
//  - Registered data-phase select; per-slave SPLIT blocking; boot remap.
//  - Built-in default slave returning the two-cycle AHB ERROR response.

---
 rtl/ahb_decoder_master_split_pkg.sv | 28 ++
 rtl/ahb_decoder_master_split_if.sv | 30 +++
 rtl/ahb_default_slave.sv | 57 +++++
 rtl/ahb_decoder_master_split.sv | 80 ++++++++
 tb/tb_ahb_decoder_master_split.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/ahb_decoder_master_split_pkg.sv
// Shared AHB types for the per-master decoder and its built-in default slave.
package ahb_decoder_master_split_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_type;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_ERR1 = 2'b01,
    D_ERR2 = 2'b10
  } dflt_state_t;

  function automatic logic is_active(input htrans_type t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_decoder_master_split_if.sv
// Master-port view of the decoder: address-phase inputs, selects and default-slave response.
interface ahb_decoder_master_split_if
  import ahb_decoder_master_split_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned SLAVE_NUM      = 4
);
  logic [AHB_ADDR_WIDTH-1:0] haddr;
  htrans_type                htrans;
  logic                      hready;
  logic                      hremap;
  logic [SLAVE_NUM-1:0]      split_ack;
  logic [SLAVE_NUM-1:0]      hsplit;
  logic [SLAVE_NUM-1:0]      hreq;
  logic [SLAVE_NUM-1:0]      hsel_dp;
  logic                      split_wait;
  logic                      default_slv_sel;
  logic                      dflt_hready;
  hresp_type                 dflt_hresp;

  modport master (
    output haddr, htrans, hready, hremap, split_ack, hsplit,
    input  hreq, hsel_dp, split_wait, default_slv_sel, dflt_hready, dflt_hresp
  );

  modport slave (
    input  haddr, htrans, hready, hremap, split_ack, hsplit,
    output hreq, hsel_dp, split_wait, default_slv_sel, dflt_hready, dflt_hresp
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: answers any active transfer to an unmapped address with the
// two-cycle AHB ERROR response; idle/busy transfers get zero-wait OKAY.
module ahb_default_slave
  import ahb_decoder_master_split_pkg::*;
(
  input  logic      hclk,
  input  logic      hreset,
  input  logic      hready,
  input  logic      err_addr,
  output logic      dflt_hready,
  output hresp_type dflt_hresp
);

  dflt_state_t state_q;

  // The errored address phase is sampled straight into the state so the first
  // ERROR cycle lines up with the data phase that follows it.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= D_IDLE;
      dflt_hready <= 1'b1;
      dflt_hresp  <= OKAY;
    end else begin
      unique case (state_q)
        D_IDLE: begin
          if (hready && err_addr) begin
            state_q     <= D_ERR1;
            dflt_hready <= 1'b0;
            dflt_hresp  <= ERROR;
          end
        end
        D_ERR1: begin
          state_q     <= D_ERR2;
          dflt_hready <= 1'b1;
          dflt_hresp  <= ERROR;
        end
        D_ERR2: begin
          if (hready && err_addr) begin
            state_q     <= D_ERR1;
            dflt_hready <= 1'b0;
            dflt_hresp  <= ERROR;
          end else begin
            state_q     <= D_IDLE;
            dflt_hready <= 1'b1;
            dflt_hresp  <= OKAY;
          end
        end
        default: begin
          state_q     <= D_IDLE;
          dflt_hready <= 1'b1;
          dflt_hresp  <= OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_decoder_master_split.sv
// Per-master AHB address decoder with SPLIT blocking, boot remap, registered
// data-phase select and a built-in default slave.
module ahb_decoder_master_split
  import ahb_decoder_master_split_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned SLAVE_NUM      = 4,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] LOW_ADDR  = '0,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] HIGH_ADDR = '1,
  parameter int unsigned REMAP_IDX      = 1
) (
  input logic                        hclk,
  input logic                        hreset,
  ahb_decoder_master_split_if.slave  bus
);

  logic [SLAVE_NUM-1:0] hit;
  logic [SLAVE_NUM-1:0] winner;
  logic                 any_hit;
  logic                 active;
  logic                 split_wait;
  logic [SLAVE_NUM-1:0] blocked_d, blocked_q;
  logic [SLAVE_NUM-1:0] hsel_dp_q;

  always_comb begin
    hit = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      hit[i] = (bus.haddr >= LOW_ADDR[i]) && (bus.haddr <= HIGH_ADDR[i]);
    end
    // Boot remap: region 0 belongs to REMAP_IDX and slave 0 drops out.
    if (bus.hremap && hit[0]) begin
      hit[0]         = 1'b0;
      hit[REMAP_IDX] = 1'b1;
    end
  end

  always_comb begin
    winner  = '0;
    any_hit = 1'b0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (hit[i] && !any_hit) begin
        winner[i] = 1'b1;
        any_hit   = 1'b1;
      end
    end
  end

  assign active     = is_active(bus.htrans);
  assign split_wait = active && ((winner & blocked_q) != '0);

  assign bus.hreq            = active ? (winner & ~blocked_q) : '0;
  assign bus.split_wait      = split_wait;
  assign bus.default_slv_sel = active && !any_hit && !split_wait;
  assign bus.hsel_dp         = hsel_dp_q;

  // Set has priority over a release in the same cycle.
  assign blocked_d = (blocked_q & ~bus.hsplit) | bus.split_ack;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      blocked_q <= '0;
      hsel_dp_q <= '0;
    end else begin
      blocked_q <= blocked_d;
      if (bus.hready) begin
        hsel_dp_q <= winner;
      end
    end
  end

  ahb_default_slave u_default_slave (
    .hclk        (hclk),
    .hreset      (hreset),
    .hready      (bus.hready),
    .err_addr    (active && !any_hit),
    .dflt_hready (bus.dflt_hready),
    .dflt_hresp  (bus.dflt_hresp)
  );

endmodule

// File: tb/tb_ahb_decoder_master_split.sv
// Directed bench for the AHB master-side decoder with a data-phase scoreboard.
module tb_ahb_decoder_master_split;
  import ahb_decoder_master_split_pkg::*;

  localparam logic [3:0][31:0] LOW  = {32'h0000_3000, 32'h0000_2000, 32'h0000_0400, 32'h0000_0000};
  localparam logic [3:0][31:0] HIGH = {32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_07FF, 32'h0000_03FF};

  logic hclk = 1'b0;
  logic hreset;
  logic tb_hready;

  ahb_decoder_master_split_if #(.AHB_ADDR_WIDTH(32), .SLAVE_NUM(4)) bus ();

  // Other slaves are zero-wait, so global HREADY only stalls on the default slave.
  assign bus.hready = tb_hready & bus.dflt_hready;

  ahb_decoder_master_split #(
    .AHB_ADDR_WIDTH (32),
    .SLAVE_NUM      (4),
    .LOW_ADDR       (LOW),
    .HIGH_ADDR      (HIGH),
    .REMAP_IDX      (1)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    string     tag;
    logic [3:0] dp;
    logic      rdy;
    hresp_type resp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one address phase, check the combinational decode, then the registered state.
  task automatic step(input string tag, input htrans_type tr, input logic [31:0] a,
                      input logic [3:0] e_hreq, input logic e_sw, input logic e_ds,
                      input logic [3:0] e_dp, input logic e_rdy, input hresp_type e_resp);
    exp_t e;
    @(negedge hclk);
    bus.htrans = tr;
    bus.haddr  = a;
    #1;
    check({tag, ".hreq"}, 32'(bus.hreq), 32'(e_hreq));
    check({tag, ".split_wait"}, 32'(bus.split_wait), 32'(e_sw));
    check({tag, ".default_slv_sel"}, 32'(bus.default_slv_sel), 32'(e_ds));
    sb.push_back('{tag: tag, dp: e_dp, rdy: e_rdy, resp: e_resp});
    @(posedge hclk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".hsel_dp"}, 32'(bus.hsel_dp), 32'(e.dp));
      check({e.tag, ".dflt_hready"}, 32'(bus.dflt_hready), 32'(e.rdy));
      check({e.tag, ".dflt_hresp"}, 32'(bus.dflt_hresp), 32'(e.resp));
    end
  endtask

  task automatic pulse(input logic [3:0] ack, input logic [3:0] rel);
    @(negedge hclk);
    bus.split_ack = ack;
    bus.hsplit    = rel;
    @(posedge hclk);
    #1;
    bus.split_ack = '0;
    bus.hsplit    = '0;
  endtask

  initial begin
    hreset        = 1'b1;
    tb_hready     = 1'b1;
    bus.htrans    = IDLE;
    bus.haddr     = '0;
    bus.hremap    = 1'b0;
    bus.split_ack = '0;
    bus.hsplit    = '0;
    repeat (2) @(posedge hclk);
    #1;
    check("reset.hsel_dp", 32'(bus.hsel_dp), 32'h0);
    check("reset.dflt_hready", 32'(bus.dflt_hready), 32'h1);
    check("reset.dflt_hresp", 32'(bus.dflt_hresp), 32'(OKAY));
    check("reset.hreq", 32'(bus.hreq), 32'h0);
    @(negedge hclk);
    hreset = 1'b0;

    step("s1_0400",     NONSEQ, 32'h0000_0400, 4'b0010, 0, 0, 4'b0010, 1, OKAY);
    step("s2_high1",    NONSEQ, 32'h0000_07FF, 4'b0010, 0, 0, 4'b0010, 1, OKAY);
    step("s3_hole",     NONSEQ, 32'h0000_0800, 4'b0000, 0, 1, 4'b0000, 0, ERROR);
    step("s4_hold",     NONSEQ, 32'h0000_0800, 4'b0000, 0, 1, 4'b0000, 1, ERROR);
    step("s5_b2b",      NONSEQ, 32'h0000_1000, 4'b0000, 0, 1, 4'b0000, 0, ERROR);
    step("s6_err1",     IDLE,   32'h0000_0000, 4'b0000, 0, 0, 4'b0000, 1, ERROR);
    step("s7_idle",     IDLE,   32'h0000_0000, 4'b0000, 0, 0, 4'b0001, 1, OKAY);
    step("s8_idlehole", IDLE,   32'h0000_0800, 4'b0000, 0, 0, 4'b0000, 1, OKAY);

    pulse(4'b0100, 4'b0000);
    step("s9_split",    NONSEQ, 32'h0000_2410, 4'b0000, 1, 0, 4'b0100, 1, OKAY);
    pulse(4'b0000, 4'b0100);
    step("s10_rel",     NONSEQ, 32'h0000_2410, 4'b0100, 0, 0, 4'b0100, 1, OKAY);
    pulse(4'b1000, 4'b1000);
    step("s11_setwin",  NONSEQ, 32'h0000_3000, 4'b0000, 1, 0, 4'b1000, 1, OKAY);
    pulse(4'b0000, 4'b1000);
    step("s12_seq",     SEQ,    32'h0000_3004, 4'b1000, 0, 0, 4'b1000, 1, OKAY);

    bus.hremap = 1'b1;
    step("s13_remap1",  NONSEQ, 32'h0000_0010, 4'b0010, 0, 0, 4'b0010, 1, OKAY);
    bus.hremap = 1'b0;
    step("s14_remap0",  NONSEQ, 32'h0000_0010, 4'b0001, 0, 0, 4'b0001, 1, OKAY);
    step("s15_busy",    BUSY,   32'h0000_0400, 4'b0000, 0, 0, 4'b0010, 1, OKAY);

    tb_hready = 1'b0;
    step("s16_wait",    NONSEQ, 32'h0000_2000, 4'b0100, 0, 0, 4'b0010, 1, OKAY);
    step("s17_wait",    NONSEQ, 32'h0000_3000, 4'b1000, 0, 0, 4'b0010, 1, OKAY);
    step("s18_wait",    NONSEQ, 32'h0000_0000, 4'b0001, 0, 0, 4'b0010, 1, OKAY);
    tb_hready = 1'b1;

    pulse(4'b0100, 4'b0000);
    step("s19_hole",    NONSEQ, 32'h0000_0800, 4'b0000, 0, 1, 4'b0000, 0, ERROR);
    #2;
    hreset = 1'b1;
    #1;
    check("rst_err1.dflt_hready", 32'(bus.dflt_hready), 32'h1);
    check("rst_err1.dflt_hresp", 32'(bus.dflt_hresp), 32'(OKAY));
    check("rst_err1.hsel_dp", 32'(bus.hsel_dp), 32'h0);
    bus.htrans = IDLE;
    #1;
    check("rst_idle.hreq", 32'(bus.hreq), 32'h0);
    check("rst_idle.default_slv_sel", 32'(bus.default_slv_sel), 32'h0);
    @(negedge hclk);
    hreset = 1'b0;
    step("s20_unblock", NONSEQ, 32'h0000_2410, 4'b0100, 0, 0, 4'b0100, 1, OKAY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
